// File: rtl/mem_sync_ctrl.sv
// Clocked single-port RAM with a shared bidirectional data bus, req/ack handshake and programmable read latency.
// Define MEM_CLEAR_EN to zero-fill every word after reset (INIT sweep, busy held high meanwhile).
module mem_sync_ctrl #(
   parameter int unsigned DWIDTH = 8,
   parameter int unsigned AWIDTH = 5,
   parameter int unsigned RD_LAT = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req,
   input  logic              we,
   input  logic [AWIDTH-1:0] addr,
   inout  wire  [DWIDTH-1:0] data,
   output logic              ack,
   output logic              busy
);

   localparam int unsigned DEPTH = 2 ** AWIDTH;
   localparam int unsigned CNT_W = 3;
   localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(RD_LAT - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
`ifdef MEM_CLEAR_EN
      S_INIT = 2'd3,
`endif
      S_RESP = 2'd2
   } state_e;

`ifdef MEM_CLEAR_EN
   localparam state_e RST_STATE = S_INIT;
   localparam logic   RST_BUSY  = 1'b1;
`else
   localparam state_e RST_STATE = S_IDLE;
   localparam logic   RST_BUSY  = 1'b0;
`endif

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               ack_q, ack_d;
   logic               busy_q, busy_d;
   logic               drive_q, drive_d;
   logic               is_rd_q, is_rd_d;
   logic [DWIDTH-1:0]  rdata_q;
   logic [DWIDTH-1:0]  mem_q [DEPTH];
`ifdef MEM_CLEAR_EN
   logic [AWIDTH-1:0]  sweep_q, sweep_d;
`endif

   logic               mem_we_c;
   logic [AWIDTH-1:0]  mem_waddr_c;
   logic [DWIDTH-1:0]  mem_wdata_c;
   logic               rd_en_c;

   // Next-state, memory port steering and registered-output decode
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      is_rd_d     = is_rd_q;
      mem_we_c    = 1'b0;
      mem_waddr_c = addr;
      mem_wdata_c = data;
      rd_en_c     = 1'b0;
`ifdef MEM_CLEAR_EN
      sweep_d     = sweep_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (req) begin
               is_rd_d = ~we;
               if (we) begin
                  mem_we_c = 1'b1;
                  state_d  = S_RESP;
               end else begin
                  rd_en_c = 1'b1;
                  if (RD_LAT <= 1) begin
                     state_d = S_RESP;
                  end else begin
                     state_d = S_WAIT;
                     cnt_d   = LAT_M1;
                  end
               end
            end
         end
         S_WAIT: begin
            if (cnt_q <= CNT_W'(1)) begin
               state_d = S_RESP;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         S_RESP: begin
            state_d = S_IDLE;
         end
`ifdef MEM_CLEAR_EN
         S_INIT: begin
            mem_we_c    = 1'b1;
            mem_waddr_c = sweep_q;
            mem_wdata_c = '0;
            sweep_d     = sweep_q + AWIDTH'(1);
            if (sweep_q == AWIDTH'(DEPTH - 1)) begin
               state_d = S_IDLE;
            end
         end
`endif
         default: begin
            state_d = S_IDLE;
         end
      endcase
      ack_d   = (state_d == S_RESP);
      busy_d  = (state_d != S_IDLE);
      drive_d = ack_d & is_rd_d;
   end

   // Control registers; reset wins over any request on the same edge
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= RST_STATE;
         cnt_q   <= '0;
         ack_q   <= 1'b0;
         busy_q  <= RST_BUSY;
         drive_q <= 1'b0;
         is_rd_q <= 1'b0;
`ifdef MEM_CLEAR_EN
         sweep_q <= '0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ack_q   <= ack_d;
         busy_q  <= busy_d;
         drive_q <= drive_d;
         is_rd_q <= is_rd_d;
`ifdef MEM_CLEAR_EN
         sweep_q <= sweep_d;
`endif
      end
   end

   // Storage array and read register are not cleared by reset
   always_ff @(posedge clk) begin
      if (!rst && mem_we_c) begin
         mem_q[mem_waddr_c] <= mem_wdata_c;
      end
      if (!rst && rd_en_c) begin
         rdata_q <= mem_q[addr];
      end
   end

   assign data = drive_q ? rdata_q : {DWIDTH{1'bz}};
   assign ack  = ack_q;
   assign busy = busy_q;

endmodule

// File: tb/tb_mem_sync_ctrl.sv
// Scoreboarded bench for mem_sync_ctrl over three configurations (latency 1/3/4, 8- and 16-bit words).
// Honours MEM_CLEAR_EN when the design is built with it.
module tb_mem_sync_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fails  = 0;
   int n_done   = 0;
   int cyc      = 0;
   always @(posedge clk) cyc <= cyc + 1;

`ifdef MEM_CLEAR_EN
   localparam bit CLR = 1'b1;
`else
   localparam bit CLR = 1'b0;
`endif

   typedef struct {
      bit          rd;
      logic [15:0] val;
      int          cyc;
   } exp_t;

   task automatic chk(int c, string nm, longint act, longint exp);
      n_checks++;
      if (act !== exp) begin
         n_fails++;
         $display("FAIL cfg%0d %s: got 0x%0h expected 0x%0h", c, nm, act, exp);
      end
   endtask

   for (genvar g = 0; g < 3; g++) begin : cfg
      localparam int unsigned DW    = (g == 2) ? 16 : 8;
      localparam int unsigned AW    = (g == 2) ? 4 : 5;
      localparam int unsigned LAT   = (g == 0) ? 1 : ((g == 1) ? 3 : 4);
      localparam int unsigned DEPTH = 1 << AW;

      logic          rst, req, we, tb_drive, started;
      logic [AW-1:0] addr;
      logic [DW-1:0] tb_data;
      wire  [DW-1:0] data;
      logic          ack, busy;

      logic [15:0]   mdl [DEPTH];
      bit            known [DEPTH];
      exp_t          sb [$];

      assign data = tb_drive ? tb_data : {DW{1'bz}};

      mem_sync_ctrl #(.DWIDTH(DW), .AWIDTH(AW), .RD_LAT(LAT)) dut (
         .clk  (clk),
         .rst  (rst),
         .req  (req),
         .we   (we),
         .addr (addr),
         .data (data),
         .ack  (ack),
         .busy (busy)
      );

      // Monitor: every cycle compares ack against the queue head, then read data or bus release
      always @(negedge clk) begin
         if (started) begin
            bit exp_ack;
            exp_ack = 1'b0;
            if (sb.size() > 0) exp_ack = (sb[0].cyc == cyc);
            chk(g, "ack", ack, exp_ack);
            if (exp_ack && sb[0].rd) chk(g, "rd_data", data, sb[0].val);
            else if (tb_drive) chk(g, "bus_release", data, tb_data);
            if (sb.size() > 0) begin
               if (sb[0].cyc <= cyc) void'(sb.pop_front());
            end
         end
      end

      task automatic wait_idle();
         int n;
         n = 0;
         while (busy !== 1'b0 && n < 80) begin
            @(posedge clk); #1;
            n++;
         end
         if (busy !== 1'b0) chk(g, "busy_timeout", busy, 0);
      endtask

      task automatic op(bit w, int a, logic [15:0] v);
         wait_idle();
         req      = 1'b1;
         we       = w;
         addr     = AW'(a);
         tb_drive = w;
         if (w) tb_data = DW'(v);
         @(posedge clk); #1;
         if (w) begin
            mdl[a]   = 16'(DW'(v));
            known[a] = 1'b1;
            sb.push_back('{rd: 1'b0, val: 16'h0, cyc: cyc});
         end else begin
            sb.push_back('{rd: 1'b1, val: mdl[a], cyc: cyc + int'(LAT) - 1});
         end
         // Junk request held while busy must be ignored
         req  = ($urandom_range(0, 1) == 1);
         we   = ($urandom_range(0, 1) == 1);
         addr = AW'($urandom);
         if (w) tb_data = DW'($urandom);
      endtask

      task automatic read_then_reset(int a);
         wait_idle();
         req      = 1'b1;
         we       = 1'b0;
         addr     = AW'(a);
         tb_drive = 1'b0;
         @(posedge clk); #1;
         req = 1'b0;
         @(posedge clk); #1;
         rst = 1'b1;
         @(posedge clk); #1;
         rst = 1'b0;
         chk(g, "midrst_ack", ack, 0);
         chk(g, "midrst_busy", busy, CLR);
         if (CLR) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
               mdl[i]   = 16'h0;
               known[i] = 1'b1;
            end
         end
         tb_drive = 1'b1;
         tb_data  = DW'($urandom);
      endtask

      initial begin
         int n;
         rst      = 1'b1;
         req      = 1'b0;
         we       = 1'b0;
         addr     = '0;
         tb_drive = 1'b0;
         tb_data  = '0;
         started  = 1'b0;
         for (int i = 0; i < int'(DEPTH); i++) begin
            mdl[i]   = 16'h0;
            known[i] = CLR;
         end
         repeat (2) @(posedge clk);
         #1;
         chk(g, "reset_ack", ack, 0);
         chk(g, "reset_busy", busy, CLR);
         rst     = 1'b0;
         started = 1'b1;
         n = 0;
         while (busy === 1'b1 && n < 100) begin
            @(posedge clk); #1;
            n++;
         end
         chk(g, "sweep_cycles", n, CLR ? DEPTH : 0);
         if (CLR) op(1'b0, 5, 16'h0);
         op(1'b1, 3, 16'hA5);
         op(1'b0, 3, 16'h0);
         op(1'b1, 7, 16'h3C);
         op(1'b0, 7, 16'h0);
         op(1'b1, DEPTH - 1, 16'hFF);
         op(1'b1, 0, 16'h11);
         op(1'b0, DEPTH - 1, 16'h0);
         op(1'b0, 0, 16'h0);
         op(1'b1, DEPTH - 1, 16'hBEEF);
         op(1'b0, DEPTH - 1, 16'h0);
         op(1'b0, 0, 16'h0);
         if (LAT >= 3) begin
            read_then_reset(DEPTH - 1);
            op(1'b0, DEPTH - 1, 16'h0);
         end
         repeat (60) begin
            int a;
            bit w;
            a = $urandom_range(0, DEPTH - 1);
            w = ($urandom_range(0, 1) == 1);
            if (!known[a]) w = 1'b1;
            op(w, a, 16'($urandom));
         end
         wait_idle();
         req = 1'b0;
         repeat (3) @(posedge clk);
         #1;
         chk(g, "sb_drain", sb.size(), 0);
         n_done++;
      end
   end

   initial begin
      int n;
      n = 0;
      while (n_done < 3 && n < 20000) begin
         @(posedge clk);
         n++;
      end
      chk(-1, "all_configs_done", n_done, 3);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
